branch_resolver: RTL
====================

Name: branch_resolver

Overview:
- Decode-stage write side of the branch predictor.
- Captures the fetch-stage prediction (predicted_taken, predicted target, PC) in an IF/ID holding register.
- Evaluates the real branch condition in decode and detects mispredictions.
- Drives the predictor's write port (IF_ID_PC_curr, wen, actual_taken) and the BTB update.
- Issues a one-cycle flush plus redirect PC back to fetch.

Parameters:
- PC_W, 16, PC / target width.
- IDX_W, 4, predictor index width; IF_ID_PC_curr = captured PC[IDX_W-1:0].
- CNT_W, 16, width of the saturating performance counters.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  pipeline advance; low = stall, hold all state, suppress all writes and flush.
- IF_PC_curr  in  PC_W  PC of instruction in fetch.
- IF_valid  in  1  fetch slot holds a real instruction.
- IF_predicted_taken  in  1  predictor output for IF_PC_curr.
- IF_predicted_target  in  PC_W  BTB target for IF_PC_curr.
- ID_is_branch  in  1  decoded instruction is a branch.
- ID_cond  in  3  branch condition code.
- ID_flags  in  3  {Z,V,N} flags.
- ID_branch_target  in  PC_W  computed target.
- ID_PC_next  in  PC_W  fall-through PC (PC+2).
- IF_ID_PC_curr  out  IDX_W  predictor write index.
- bht_wen  out  1  predictor write strobe.
- actual_taken  out  1  resolved direction.
- btb_wen  out  1  BTB write strobe.
- btb_target  out  PC_W  BTB write data (= ID_branch_target).
- mispredict  out  1  resolution disagrees with prediction.
- flush  out  1  kill the fetch slot and load redirect_PC.
- redirect_PC  out  PC_W  corrected next PC.
- branch_count  out  CNT_W  resolved branches.
- mispredict_count  out  CNT_W  mispredictions.

Behaviour:
- Reset (async, rst_n=0): capture register valid=0, PC=0, pred=0, target=0; state=RUN; both counters 0. All outputs therefore 0.
- Capture register: at a rising edge with enable=1, loads {IF_valid, IF_PC_curr, IF_predicted_taken, IF_predicted_target}. If flush=1 that cycle, it loads valid=0 instead. With enable=0 it holds.
- Condition eval (combinational):
  - 000 Z=0
  - 001 Z=1
  - 010 Z=0&N=0
  - 011 N=1
  - 100 Z=1|(Z=0&N=0)
  - 101 N=1|Z=1
  - 110 V=1
  - 111 always
- resolve = enable & cap_valid & ID_is_branch & (state==RUN).
- actual_taken = resolve & cond_true.
- mispredict = resolve & ((actual_taken != cap_pred) | (actual_taken & (cap_target != ID_branch_target))).
- bht_wen = resolve: the 2-bit counter trains on every resolved branch. The predictor write lands at the same clock edge. Latency is 0 cycles from decode.
- btb_wen = resolve & actual_taken & (cap_target != ID_branch_target).
- flush = mispredict.
- redirect_PC = actual_taken ? ID_branch_target : ID_PC_next; 0 when mispredict=0.
- FSM:
  - RUN -> FLUSH on mispredict.
  - FLUSH -> RUN on the next edge with enable=1.
  - FLUSH holds while enable=0.
  - In FLUSH, resolve is forced 0, so there is no double update or double flush even if the bubble slot looks valid.
- Counters:
  - branch_count +1 on resolve.
  - mispredict_count +1 on mispredict.
  - Both saturate at all-ones, with no wrap.
- Simultaneous: mispredict and IF_valid in the same cycle -> the captured slot is invalidated (flush has priority).
- enable=0 during a mispredict condition -> nothing is asserted; it is re-evaluated when enable returns.
- Reset mid-FLUSH -> RUN, outputs 0 immediately (async).
- IF_ID_PC_curr = cap_PC[IDX_W-1:0] continuously, independent of resolve.

Decomposition:
- Shared package branch_pkg:
  - condition code constants (COND_NE … COND_UNCOND)
  - FSM state encoding (RUN, FLUSH)
  - flag bit positions (Z=2, V=1, N=0)
- Sub-module branch_cond_eval: pure combinational, cond[2:0] + flags[2:0] -> cond_true.

Test Plan:
- Correct prediction: capture PC=0x0014, pred=1, target=0x0040; ID cond=001, Z=1, target=0x0040 -> actual_taken=1, bht_wen=1, IF_ID_PC_curr=4, mispredict=0, flush=0, btb_wen=0, branch_count=1.
- Direction mispredict: pred=0, cond=111 (always), target=0x0080 -> mispredict=1, flush=1, redirect_PC=0x0080, btb_wen=1. Next cycle: state FLUSH, capture valid=0, bht_wen=0, mispredict_count=1.
- Not-taken mispredict: pred=1, cond=000, Z=1, ID_PC_next=0x0016 -> actual_taken=0, flush=1, redirect_PC=0x0016, btb_wen=0.
- Target mismatch: pred=1, target=0x0040; actual taken to 0x0044 -> mispredict=1, btb_wen=1, btb_target=0x0044.
- Stall: enable=0 with a mispredicting branch in ID for 3 cycles -> no wen/flush, counters unchanged. On enable=1 -> single flush, counters +1.
- Saturation/reset: preload branch_count to 0xFFFF and resolve -> stays 0xFFFF. Assert rst_n=0 mid-FLUSH -> all outputs 0 asynchronously, state RUN.

Source files
------------

// File: rtl/branch_pkg.sv
// Shared definitions for the branch resolver: condition codes, FSM states, flag positions.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package branch_pkg;

  // Branch condition codes as decoded from the instruction.
  localparam logic [2:0] COND_NE     = 3'b000;  // Z=0
  localparam logic [2:0] COND_EQ     = 3'b001;  // Z=1
  localparam logic [2:0] COND_GT     = 3'b010;  // Z=0 & N=0
  localparam logic [2:0] COND_LT     = 3'b011;  // N=1
  localparam logic [2:0] COND_GE     = 3'b100;  // Z=1 | (Z=0 & N=0)
  localparam logic [2:0] COND_LE     = 3'b101;  // N=1 | Z=1
  localparam logic [2:0] COND_OV     = 3'b110;  // V=1
  localparam logic [2:0] COND_UNCOND = 3'b111;  // always

  // Bit positions inside the {Z,V,N} flag vector.
  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_N = 0;

  // RUN: normal resolution. FLUSH: one bubble after a redirect, no resolution.
  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

endpackage

// File: rtl/branch_cond_eval.sv
// Branch condition evaluator: cond code + {Z,V,N} flags -> cond_true.
// Latency: combinational, 0 cycles.
// Backpressure: none (pure function of its inputs).
// Ports: cond[2:0] condition code, flags[2:0] {Z,V,N}, cond_true result.
module branch_cond_eval
  import branch_pkg::*;
(
  input  logic [2:0] cond,
  input  logic [2:0] flags,
  output logic       cond_true
);

  logic z, v, n;

  assign z = flags[FLAG_Z];
  assign v = flags[FLAG_V];
  assign n = flags[FLAG_N];

  always_comb begin
    cond_true = 1'b0;
    case (cond)
      COND_NE:     cond_true = ~z;
      COND_EQ:     cond_true = z;
      COND_GT:     cond_true = ~z & ~n;
      COND_LT:     cond_true = n;
      COND_GE:     cond_true = z | (~z & ~n);
      COND_LE:     cond_true = n | z;
      COND_OV:     cond_true = v;
      COND_UNCOND: cond_true = 1'b1;
      default:     cond_true = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolver.sv
// Decode-stage branch resolution: captures the fetch prediction, resolves in ID, trains BHT/BTB, flushes on mispredict.
// Latency: resolution, predictor writes and flush/redirect are combinational in the ID cycle (0 cycles).
// Backpressure: enable=0 stalls; all state holds and every write strobe and flush is suppressed.
// Ports: clk/rst_n; enable; IF_* fetch-side prediction; ID_* decode-side branch info;
//        IF_ID_PC_curr/bht_wen/actual_taken to the BHT; btb_wen/btb_target to the BTB;
//        mispredict/flush/redirect_PC to fetch; branch_count/mispredict_count statistics.
module branch_resolver
  import branch_pkg::*;
#(
  parameter int PC_W  = 16,
  parameter int IDX_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [PC_W-1:0]  IF_PC_curr,
  input  logic             IF_valid,
  input  logic             IF_predicted_taken,
  input  logic [PC_W-1:0]  IF_predicted_target,
  input  logic             ID_is_branch,
  input  logic [2:0]       ID_cond,
  input  logic [2:0]       ID_flags,
  input  logic [PC_W-1:0]  ID_branch_target,
  input  logic [PC_W-1:0]  ID_PC_next,
  output logic [IDX_W-1:0] IF_ID_PC_curr,
  output logic             bht_wen,
  output logic             actual_taken,
  output logic             btb_wen,
  output logic [PC_W-1:0]  btb_target,
  output logic             mispredict,
  output logic             flush,
  output logic [PC_W-1:0]  redirect_PC,
  output logic [CNT_W-1:0] branch_count,
  output logic [CNT_W-1:0] mispredict_count
);

  // IF/ID holding register for the fetch-stage prediction.
  logic             cap_valid_q, cap_valid_d;
  logic [PC_W-1:0]  cap_pc_q, cap_pc_d;
  logic             cap_pred_q, cap_pred_d;
  logic [PC_W-1:0]  cap_target_q, cap_target_d;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] branch_count_q, branch_count_d;
  logic [CNT_W-1:0] mispredict_count_q, mispredict_count_d;

  logic cond_true;
  logic resolve;
  logic target_diff;

  branch_cond_eval u_cond_eval (
    .cond      (ID_cond),
    .flags     (ID_flags),
    .cond_true (cond_true)
  );

  always_comb begin
    // FLUSH gates resolution so the bubble slot can never train or redirect twice.
    resolve      = enable & cap_valid_q & ID_is_branch & (state_q == RUN);
    actual_taken = resolve & cond_true;
    target_diff  = (cap_target_q != ID_branch_target);
    mispredict   = resolve & ((actual_taken != cap_pred_q) | (actual_taken & target_diff));
    bht_wen      = resolve;
    btb_wen      = resolve & actual_taken & target_diff;
    btb_target   = ID_branch_target;
    flush        = mispredict;
    redirect_PC  = '0;
    if (mispredict) begin
      redirect_PC = actual_taken ? ID_branch_target : ID_PC_next;
    end
    IF_ID_PC_curr    = cap_pc_q[IDX_W-1:0];
    branch_count     = branch_count_q;
    mispredict_count = mispredict_count_q;
  end

  always_comb begin
    cap_valid_d        = cap_valid_q;
    cap_pc_d           = cap_pc_q;
    cap_pred_d         = cap_pred_q;
    cap_target_d       = cap_target_q;
    state_d            = state_q;
    branch_count_d     = branch_count_q;
    mispredict_count_d = mispredict_count_q;

    if (enable) begin
      // A flush kills whatever fetch is presenting this cycle.
      cap_valid_d  = IF_valid & ~flush;
      cap_pc_d     = IF_PC_curr;
      cap_pred_d   = IF_predicted_taken;
      cap_target_d = IF_predicted_target;

      case (state_q)
        RUN:     if (mispredict) state_d = FLUSH;
        FLUSH:   state_d = RUN;
        default: state_d = RUN;
      endcase
    end

    // resolve/mispredict already include enable; counters stick at all-ones.
    if (resolve && (branch_count_q != '1)) begin
      branch_count_d = branch_count_q + CNT_W'(1);
    end
    if (mispredict && (mispredict_count_q != '1)) begin
      mispredict_count_d = mispredict_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_valid_q        <= 1'b0;
      cap_pc_q           <= '0;
      cap_pred_q         <= 1'b0;
      cap_target_q       <= '0;
      state_q            <= RUN;
      branch_count_q     <= '0;
      mispredict_count_q <= '0;
    end else begin
      cap_valid_q        <= cap_valid_d;
      cap_pc_q           <= cap_pc_d;
      cap_pred_q         <= cap_pred_d;
      cap_target_q       <= cap_target_d;
      state_q            <= state_d;
      branch_count_q     <= branch_count_d;
      mispredict_count_q <= mispredict_count_d;
    end
  end

endmodule
